// File: rtl/sb_gb.sv
// Global-buffer wrapper: forwards a clock/reset net (optionally retimed on clk_4x)
// and monitors it for rising edges, activity and a stuck-at condition.
module sb_gb #(
    parameter int    REGISTERED    = 0,
    parameter int    STUCK_TIMEOUT = 1024,
    parameter string BEL           = ""
) (
    input  logic        clk_4x,
    input  logic        pll_lock,
    input  logic        USER_SIGNAL_TO_GLOBAL_BUFFER,
    output logic        GLOBAL_BUFFER_OUTPUT,
    output logic [15:0] gb_edge_cnt,
    output logic        gb_stuck,
    output logic        gb_active
);

    localparam logic [15:0] IDLE_LIMIT = 16'(STUCK_TIMEOUT);

    // BEL only tags placement for the implementation tools.
    if (BEL != "") begin : g_bel_tagged
    end

    if (REGISTERED != 0) begin : g_out_reg
        logic out_reg;

        always_ff @(posedge clk_4x or negedge pll_lock) begin
            if (!pll_lock) begin
                out_reg <= 1'b0;
            end else begin
                out_reg <= USER_SIGNAL_TO_GLOBAL_BUFFER;
            end
        end

        assign GLOBAL_BUFFER_OUTPUT = out_reg;
    end else begin : g_out_comb
        // Pure wire: independent of clk_4x and pll_lock, even in reset.
        assign GLOBAL_BUFFER_OUTPUT = USER_SIGNAL_TO_GLOBAL_BUFFER;
    end

    logic        s1_reg;
    logic        s2_reg;
    logic        s3_reg;
    logic [15:0] edge_cnt_reg;
    logic [15:0] edge_cnt_next;
    logic [15:0] idle_reg;
    logic [15:0] idle_next;
    logic        stuck_reg;
    logic        stuck_next;
    logic        active_reg;
    logic        active_next;
    logic        toggle;
    logic        rise;

    assign toggle = s2_reg ^ s3_reg;
    assign rise   = s2_reg & ~s3_reg;

    always_comb begin
        edge_cnt_next = edge_cnt_reg;
        if (rise && (edge_cnt_reg != 16'hFFFF)) begin
            edge_cnt_next = edge_cnt_reg + 16'd1;
        end

        idle_next = idle_reg;
        if (toggle) begin
            idle_next = 16'd0;
        end else if (idle_reg < IDLE_LIMIT) begin
            idle_next = idle_reg + 16'd1;
        end

        // A toggle wins over the timeout landing in the same cycle.
        stuck_next = stuck_reg;
        if (toggle) begin
            stuck_next = 1'b0;
        end else if (idle_reg == IDLE_LIMIT) begin
            stuck_next = 1'b1;
        end

        active_next = active_reg;
        if (toggle) begin
            active_next = 1'b1;
        end else if (stuck_reg) begin
            active_next = 1'b0;
        end
    end

    always_ff @(posedge clk_4x or negedge pll_lock) begin
        if (!pll_lock) begin
            s1_reg       <= 1'b0;
            s2_reg       <= 1'b0;
            s3_reg       <= 1'b0;
            edge_cnt_reg <= 16'd0;
            idle_reg     <= 16'd0;
            stuck_reg    <= 1'b0;
            active_reg   <= 1'b0;
        end else begin
            s1_reg       <= USER_SIGNAL_TO_GLOBAL_BUFFER;
            s2_reg       <= s1_reg;
            s3_reg       <= s2_reg;
            edge_cnt_reg <= edge_cnt_next;
            idle_reg     <= idle_next;
            stuck_reg    <= stuck_next;
            active_reg   <= active_next;
        end
    end

    assign gb_edge_cnt = edge_cnt_reg;
    assign gb_stuck    = stuck_reg;
    assign gb_active   = active_reg;

endmodule

// File: tb/tb_sb_gb.sv
// Bench for sb_gb: one pass-through and one registered instance share stimulus;
// a reference model feeds a scoreboard that a negedge monitor drains.
module tb_sb_gb;

    localparam int T = 8;

    logic        clk_4x   = 1'b0;
    bit          clk_en   = 1'b0;
    logic        pll_lock = 1'b0;
    logic        din      = 1'b0;

    logic        out_c;
    logic [15:0] cnt_c;
    logic        stuck_c;
    logic        active_c;
    logic        out_r;
    logic [15:0] cnt_r;
    logic        stuck_r;
    logic        active_r;

    int checks   = 0;
    int failures = 0;

    always begin
        #5;
        if (clk_en) clk_4x = ~clk_4x;
    end

    sb_gb #(.REGISTERED(0), .STUCK_TIMEOUT(T), .BEL("X0Y0")) u_comb (
        .clk_4x(clk_4x),
        .pll_lock(pll_lock),
        .USER_SIGNAL_TO_GLOBAL_BUFFER(din),
        .GLOBAL_BUFFER_OUTPUT(out_c),
        .gb_edge_cnt(cnt_c),
        .gb_stuck(stuck_c),
        .gb_active(active_c)
    );

    sb_gb #(.REGISTERED(1), .STUCK_TIMEOUT(T)) u_reg (
        .clk_4x(clk_4x),
        .pll_lock(pll_lock),
        .USER_SIGNAL_TO_GLOBAL_BUFFER(din),
        .GLOBAL_BUFFER_OUTPUT(out_r),
        .gb_edge_cnt(cnt_r),
        .gb_stuck(stuck_r),
        .gb_active(active_r)
    );

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: samples since reset, edges counted on the 2-cycle-delayed
    // view, stuck from the number of quiet cycles since the last toggle.
    typedef struct packed {
        logic        out;
        logic [15:0] cnt;
        logic        stuck;
        logic        active;
    } exp_t;

    exp_t exp_q[$];
    bit   hist[$];
    int   m_cnt;
    int   m_quiet;
    bit   m_stuck;
    bit   m_active;

    task automatic model_reset();
        hist.delete();
        m_cnt    = 0;
        m_quiet  = 0;
        m_stuck  = 1'b0;
        m_active = 1'b0;
    endtask

    task automatic model_edge(input bit smp);
        int   n;
        bit   cur;
        bit   prv;
        bit   tog;
        bit   was_stuck;
        exp_t e;
        hist.push_back(smp);
        n   = hist.size() - 1;
        cur = (n >= 2) ? hist[n-2] : 1'b0;
        prv = (n >= 3) ? hist[n-3] : 1'b0;
        tog = (cur != prv);
        if (cur && !prv && m_cnt < 65535) m_cnt++;
        was_stuck = m_stuck;
        m_stuck   = !tog && (m_quiet >= T);
        m_active  = tog ? 1'b1 : (was_stuck ? 1'b0 : m_active);
        m_quiet   = tog ? 0 : m_quiet + 1;
        e.out    = smp;
        e.cnt    = 16'(m_cnt);
        e.stuck  = m_stuck;
        e.active = m_active;
        exp_q.push_back(e);
    endtask

    always @(negedge clk_4x) begin
        exp_t e;
        if (pll_lock && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out_reg",    int'(out_r),    int'(e.out));
            chk("cnt_reg",    int'(cnt_r),    int'(e.cnt));
            chk("stuck_reg",  int'(stuck_r),  int'(e.stuck));
            chk("active_reg", int'(active_r), int'(e.active));
            chk("cnt_comb",   int'(cnt_c),    int'(e.cnt));
            chk("stuck_comb", int'(stuck_c),  int'(e.stuck));
            chk("active_comb",int'(active_c), int'(e.active));
        end
    end

    // Entered just after a negedge; leaves just after the following negedge.
    task automatic cycle(input bit v);
        din = v;
        #1;
        chk("comb_follow", int'(out_c), int'(v));
        @(posedge clk_4x);
        model_edge(din);
        @(negedge clk_4x);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_cnt_r"},    int'(cnt_r),    0);
        chk({tag, "_stuck_r"},  int'(stuck_r),  0);
        chk({tag, "_active_r"}, int'(active_r), 0);
        chk({tag, "_cnt_c"},    int'(cnt_c),    0);
        chk({tag, "_stuck_c"},  int'(stuck_c),  0);
        chk({tag, "_active_c"}, int'(active_c), 0);
        chk({tag, "_out_r"},    int'(out_r),    0);
    endtask

    task automatic pulse_reset(input int hold);
        pll_lock = 1'b0;
        #1;
        chk_zero("rst_async");
        din = 1'b1;
        repeat (hold) @(negedge clk_4x);
        #1;
        chk_zero("rst_hold");
        chk("rst_comb_out", int'(out_c), 1);
        pll_lock = 1'b1;
        model_reset();
    endtask

    task automatic random_run(input int cycles);
        bit v = din;
        int left = cycles;
        while (left > 0) begin
            int len = $urandom_range(1, 12);
            v = ~v;
            for (int k = 0; k < len && left > 0; k++) begin
                cycle(v);
                left--;
            end
        end
    endtask

    initial begin
        int guard;
        model_reset();

        // Clock stopped, reset held: monitor cleared, pass-through still live.
        #3;
        chk_zero("init");
        for (int k = 0; k < 4; k++) begin
            din = (k % 2 == 0);
            #1;
            chk("comb_no_clk", int'(out_c), int'(din));
            chk("reg_no_clk",  int'(out_r), 0);
        end
        din = 1'b0;

        clk_en = 1'b1;
        @(negedge clk_4x);
        #1;
        pll_lock = 1'b1;

        // Square wave, period 4 cycles, for 40 cycles.
        for (int i = 0; i < 40; i++) cycle((i % 4) < 2);
        chk("sq_cnt_lo", int'(cnt_r >= 16'd9), 1);
        chk("sq_cnt_hi", int'(cnt_r <= 16'd11), 1);
        chk("sq_active", int'(active_r), 1);
        chk("sq_stuck",  int'(stuck_r),  0);

        // Hold low until stuck, then one toggle revives it.
        for (int i = 0; i < 20; i++) cycle(1'b0);
        chk("hold_stuck",  int'(stuck_r),  1);
        chk("hold_active", int'(active_r), 0);
        for (int i = 0; i < 4; i++) cycle(1'b1);
        chk("revive_stuck",  int'(stuck_r),  0);
        chk("revive_active", int'(active_r), 1);
        for (int i = 0; i < 14; i++) cycle(1'b1);

        random_run(300);

        // Count to 37, then reset mid-operation with the input held high.
        guard = 0;
        while (m_cnt != 37 && guard < 300) begin
            cycle(~din);
            guard++;
        end
        chk("reach_37", m_cnt, 37);
        chk("cnt_at_37", int'(cnt_r), 37);
        if (!din) cycle(1'b1);
        pulse_reset(3);
        for (int i = 0; i < 5; i++) cycle(1'b1);
        chk("held_high_edge", int'(cnt_r), 1);

        random_run(100);

        // Preload near saturation instead of running 65540 real edges.
        force u_reg.edge_cnt_reg  = 16'hFFF0;
        force u_comb.edge_cnt_reg = 16'hFFF0;
        #1;
        release u_reg.edge_cnt_reg;
        release u_comb.edge_cnt_reg;
        m_cnt = 16'hFFF0;
        for (int i = 0; i < 60; i++) cycle(~din);
        chk("sat_cnt", int'(cnt_r), 16'hFFFF);

        random_run(200);
        pulse_reset(2);
        random_run(100);

        @(negedge clk_4x);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sb_gb.md
SB_GB -- requirements
Module: sb_gb

Interface
REQ-001 Parameter REGISTERED, default 0: 0 = combinational pass-through; 1 = output registered on clk_4x.
REQ-002 Parameter STUCK_TIMEOUT, default 1024: number of clk_4x cycles without an input toggle before gb_stuck asserts; legal range 2..65535.
REQ-003 Parameter BEL, default "" (string): placement metadata only; no functional effect.
REQ-004 clk_4x  input  1  sampling/register clock, rising edge.
REQ-005 pll_lock  input  1  reset, asynchronous, active-low (0 = reset).
REQ-006 USER_SIGNAL_TO_GLOBAL_BUFFER  input  1  signal to be distributed (clock, divided clock or reset).
REQ-007 GLOBAL_BUFFER_OUTPUT  output  1  buffered copy of the input.
REQ-008 gb_edge_cnt  output  16  count of detected input rising edges.
REQ-009 gb_stuck  output  1  input has not toggled for STUCK_TIMEOUT cycles.
REQ-010 gb_active  output  1  at least one toggle detected since reset and gb_stuck low.

Function
REQ-011 When REGISTERED=0, GLOBAL_BUFFER_OUTPUT SHALL equal USER_SIGNAL_TO_GLOBAL_BUFFER combinationally, with zero cycles of latency.
REQ-012 When REGISTERED=0, the output path SHALL be unaffected by clk_4x and pll_lock, including during reset.
REQ-013 When REGISTERED=1, GLOBAL_BUFFER_OUTPUT SHALL equal the input captured on the previous clk_4x rising edge (1-cycle latency).
REQ-014 Input monitoring SHALL use a two-flop synchronizer on clk_4x (s1, s2) plus a history flop (s3); synchronizer latency is 2 cycles.
REQ-015 A rising edge is s2=1 and s3=0; a toggle is s2!=s3.
REQ-016 gb_edge_cnt SHALL increment by 1 on each detected rising edge.
REQ-017 gb_edge_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-018 An internal 16-bit idle counter SHALL clear to 0 on any toggle.
REQ-019 When there is no toggle, the idle counter SHALL increment each cycle and saturate at STUCK_TIMEOUT.
REQ-020 gb_stuck SHALL be registered: it is 1 in the cycle after the idle counter equals STUCK_TIMEOUT, and 0 in the cycle after a toggle.
REQ-021 A toggle in the same cycle that the idle counter reaches STUCK_TIMEOUT SHALL take priority: gb_stuck stays 0.
REQ-022 gb_active SHALL be registered, set by the first toggle after reset and cleared whenever gb_stuck is 1.
REQ-023 After being cleared, gb_active SHALL set again on the next toggle.
REQ-024 No other outputs, handshakes or state machines exist.

Reset
REQ-025 pll_lock=0 SHALL asynchronously clear s1, s2, s3, the idle counter, gb_edge_cnt, gb_stuck and gb_active to 0.
REQ-026 When REGISTERED=1, pll_lock=0 SHALL also clear GLOBAL_BUFFER_OUTPUT to 0.
REQ-027 Reset release SHALL be synchronous in effect: state updates resume on the first clk_4x rising edge with pll_lock=1.
REQ-028 An input held at 1 through reset release SHALL count as one rising edge once it reaches s2.
REQ-029 Reset asserted mid-operation SHALL discard all counts immediately; no pending edge survives.

Verification
REQ-030 REGISTERED=0; drive the input 0->1->0 with clk_4x stopped and pll_lock=0 -> the output follows the input immediately at every change.
REQ-031 REGISTERED=1; drive input 1 at cycle N -> output 1 at cycle N+1; assert pll_lock=0 -> output is 0 asynchronously.
REQ-032 Drive a square wave of period 4 cycles for 40 cycles after reset -> gb_edge_cnt=10 (±1 for the synchronizer boundary); gb_active=1; gb_stuck=0.
REQ-033 STUCK_TIMEOUT=8; toggle the input once, then hold it -> gb_stuck=1 exactly 8+1 cycles after s2 toggles; gb_active=0 the following cycle; one further toggle clears gb_stuck and sets gb_active.
REQ-034 Force 65540 rising edges -> gb_edge_cnt=16'hFFFF, with no wrap to 0.
REQ-035 Pulse pll_lock low mid-count with gb_edge_cnt=37 -> all monitor outputs read 0 while reset is asserted; counting restarts from 0 after release.
